// File: rtl/alu_pkg.sv
// alu_pkg: ALU opcodes, datapath width and response-slot states shared by the ALU arbiter.
package alu_pkg;
    localparam int DATA_W = 32;
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_SLTU = 3'b010;
    localparam logic [2:0] ALU_ORI1 = 3'b011;
    localparam logic [2:0] ALU_SLL  = 3'b100;
    localparam logic [2:0] ALU_OR   = 3'b101;
    localparam logic [2:0] ALU_AND  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;
    typedef enum logic {ST_IDLE, ST_HOLD} state_t;
endpackage

// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: two-requester valid/ready request bus plus the shared tagged response channel.
interface alu_share_arbiter_if;
    import alu_pkg::*;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [DATA_W-1:0] req_a0, req_b0, req_a1, req_b1;
    logic [2:0]        req_op0, req_op1;
    logic              rsp_valid, rsp_ready, rsp_id, rsp_zero;
    logic [DATA_W-1:0] rsp_result;
    modport master (
        output req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero
    );
    modport slave (
        input  req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero
    );
endinterface

// File: rtl/alu_share_arbiter_alu.sv
// alu_share_arbiter_alu: the existing combinational 32-bit ALU with Zero flag.
module alu_share_arbiter_alu
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [2:0]        i_op,
    output logic              o_zero,
    output logic [DATA_W-1:0] o_result
);
    always_comb begin
        o_result = '0;
        case (i_op)
            ALU_ADD:  o_result = i_a + i_b;
            ALU_SUB:  o_result = i_a - i_b;
            ALU_SLTU: o_result = {{(DATA_W-1){1'b0}}, i_a < i_b};
            ALU_ORI1: o_result = i_a | {{(DATA_W-1){1'b0}}, 1'b1};
            ALU_SLL:  o_result = i_b << i_a;
            ALU_OR:   o_result = i_a | i_b;
            ALU_AND:  o_result = i_a & i_b;
            ALU_SLT:  o_result = {{(DATA_W-1){1'b0}}, $signed(i_a) < $signed(i_b)};
            default:  o_result = '0;
        endcase
    end
    assign o_zero = (o_result == '0);
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one ALU between two requesters,
// with a single registered response slot returned tagged by requester id.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter logic RR_INIT = 1'b0
) (
    input  logic                i_clk,
    input  logic                i_rst,
    alu_share_arbiter_if.slave  io_bus,
    output logic [15:0]         o_ops_done
);
    state_t            r_state, w_next_state;
    logic              r_prio, r_id, r_zero;
    logic [DATA_W-1:0] r_result;
    logic [15:0]       r_ops_done;
    logic              w_slot_free, w_fire, w_win, w_zero;
    logic [1:0]        w_grant, w_ready;
    logic [DATA_W-1:0] w_a, w_b, w_result;
    logic [2:0]        w_op;

    assign w_slot_free = (r_state == ST_IDLE) | ((r_state == ST_HOLD) & io_bus.rsp_ready);
    assign w_grant     = (&io_bus.req_valid) ? (r_prio ? 2'b10 : 2'b01) : io_bus.req_valid;
    assign w_ready     = i_rst ? 2'b00 : (w_grant & {2{w_slot_free}});
    assign w_fire      = |w_ready;
    // Operand mux follows the grant, not ready, so it stays off the rsp_ready path.
    assign w_win = w_grant[1];
    assign w_a   = w_win ? io_bus.req_a1  : io_bus.req_a0;
    assign w_b   = w_win ? io_bus.req_b1  : io_bus.req_b0;
    assign w_op  = w_win ? io_bus.req_op1 : io_bus.req_op0;

    alu_share_arbiter_alu u_alu (
        .i_a      (w_a),
        .i_b      (w_b),
        .i_op     (w_op),
        .o_zero   (w_zero),
        .o_result (w_result)
    );

    always_ff @(posedge i_clk) begin
        r_state <= i_rst ? ST_IDLE : w_next_state;
    end

    always_comb begin
        w_next_state = w_fire ? ST_HOLD : (io_bus.rsp_ready ? ST_IDLE : r_state);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prio     <= RR_INIT;
            r_id       <= 1'b0;
            r_zero     <= 1'b0;
            r_result   <= '0;
            r_ops_done <= '0;
        end else if (w_fire) begin
            r_prio     <= ~w_win;
            r_id       <= w_win;
            r_zero     <= w_zero;
            r_result   <= w_result;
            r_ops_done <= r_ops_done + 16'd1;
        end
    end

    assign io_bus.req_ready  = w_ready;
    assign io_bus.rsp_valid  = (r_state == ST_HOLD);
    assign io_bus.rsp_id     = r_id;
    assign io_bus.rsp_result = r_result;
    assign io_bus.rsp_zero   = r_zero;
    assign o_ops_done        = r_ops_done;
endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares the single combinational 32-bit ALU between two independent requesters, for example an integer issue port and an address-generation unit. Each requester presents operands and an ALUOp under a valid/ready handshake. A round-robin arbiter picks one request per cycle, drives the ALU, and registers the result and Zero flag into one response slot. That slot is returned on a shared response channel tagged with the requester id.

## Interface
- RR_INIT, default 1'b0: requester that holds priority after reset.
- CLK  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- req_valid[1:0]  in  2  request valid, one bit per requester.
- req_ready[1:0]  out  2  request accepted this cycle, one bit per requester.
- req_A0, req_B0  in  32 each  operands, requester 0.
- req_op0  in  3  ALUOp, requester 0.
- req_A1, req_B1  in  32 each  operands, requester 1.
- req_op1  in  3  ALUOp, requester 1.
- rsp_valid  out  1  response slot is occupied.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester that issued the response.
- rsp_result  out  32  registered ALU result.
- rsp_zero  out  1  registered Zero flag; 1 iff rsp_result == 0.
- ops_done  out  16  count of accepted requests; wraps.

## Operation
- **ALUOp encoding:**
  - 000 add
  - 001 sub
  - 010 unsigned less-than (result 0/1)
  - 011 A|1
  - 100 B<<A
  - 101 or
  - 110 and
  - 111 signed less-than (result 0/1)
- **State machine, two states:**
  - IDLE: slot empty.
  - HOLD: slot full, rsp_valid=1.
- **Slot free condition:** slot_free = (state==IDLE) | (rsp_valid & rsp_ready).
- **Grant rule:**
  - Only one req_valid set: that requester wins, regardless of priority.
  - Both set: the requester named by prio wins.
  - req_ready[i] = grant[i] & slot_free. The loser sees req_ready=0 and must hold its request stable.
- **Accept (fire = |(req_valid & req_ready)):**
  - ALU inputs are muxed combinationally from the winner.
  - Result, Zero and winner id are captured into the slot.
  - State becomes HOLD.
  - prio is set to the non-winner.
  - ops_done increments by 1, wrapping FFFF→0000.
- **Response-only cycle:** rsp_valid & rsp_ready with no fire → IDLE.
- **Response and new request in the same cycle:** the slot is reloaded and state stays HOLD. This gives full throughput.
- **Backpressure:** rsp_valid & ~rsp_ready → rsp_id, rsp_result and rsp_zero are held bit-stable, and req_ready=2'b00.
- **No request:** prio is unchanged.
- **Reset (sync, any state including HOLD):**
  - The held response is discarded.
  - state=IDLE, prio=RR_INIT, ops_done=0.

## Timing
- **Reset values:**
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, ops_done=0.
  - req_ready=2'b00 throughout any cycle in which Reset is high.
- **Latency:** a request accepted at edge N shows rsp_valid=1 with its data after edge N, i.e. 1 cycle.
- **Throughput:** 1 operation per cycle while rsp_ready=1.
- **Response data:** rsp_* change only on an accept edge; never combinationally from req_*.
- **Ready paths:** req_ready depends combinationally on req_valid, rsp_ready and state. No path exists from req_* to rsp_*.
- **Critical path:** operand mux → ALU → result register. It must close at the ALU's own frequency plus one 2:1 mux.

## Structure
- **Shared package (alu_pkg):**
  - ALUOp localparams: ALU_ADD, ALU_SUB, ALU_SLTU, ALU_ORI1, ALU_SLL, ALU_OR, ALU_AND, ALU_SLT.
  - DATA_W=32.
  - State encoding: ST_IDLE, ST_HOLD.
- **Sub-module:** one instance of the existing ALU (A, B, ALUOp, Zero, result).
- **Top-level logic:** arbitration, slot registers and counter stay inline in the top module.
- **Round-robin logic:** may be factored into rr_arb2 (req[1:0], prio, grant[1:0]). This is the only other natural sub-module.

## Test plan
- Reset, then req0 op=000, A=5, B=7 → next cycle: rsp_valid=1, rsp_id=0, rsp_result=12, rsp_zero=0, ops_done=1.
- Both requesters valid with prio=0:
  - req0 op=001, A=3, B=3.
  - req1 op=101, A=F0, B=0F.
  - → response 1: id0, result 0, zero=1.
  - → response 2: id1, result FF.
  - → prio returns to 0.
- Hold rsp_ready=0 for 3 cycles with both requests pending → rsp_* bit-stable and req_ready=00.
  - Raise rsp_ready → same cycle: old response retired, next request accepted.
  - → no bubble.
- Signed versus unsigned compare, A=FFFFFFFF, B=1:
  - op 111 → 1.
  - op 010 → 0, zero=1.
  - Shift check: op 100, A=4, B=1 → 16.
- Assert Reset while in HOLD with rsp_ready=0 → next cycle: rsp_valid=0, rsp_result=0, ops_done=0, prio=RR_INIT.
- 65536 back-to-back accepts with rsp_ready=1 → ops_done wraps to 0. No response lost; ids alternate when both requesters are valid.
